// File: rtl/isa_pkg.sv
// Shared ISA definitions for the 16-bit core: op enum, opcode/condition codes, field positions.
// encode() packs one field bundle into an instruction word and is reused as a golden model.
package isa_pkg;

  typedef enum logic [4:0] {
    OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_LHI, OP_LLI, OP_LDR, OP_STR,
    OP_CMP, OP_ADDI, OP_SUBI, OP_MOV, OP_BEQ, OP_BNE, OP_BCS, OP_BCC,
    OP_BAL, OP_JMP, OP_JAL, OP_JALR, OP_JR, OP_OUTR, OP_HLT
  } op_e;

  localparam logic [4:0] OP_COUNT = 5'd23;

  localparam logic [4:0] OPC_ALU  = 5'b00000;
  localparam logic [4:0] OPC_LHI  = 5'b00001;
  localparam logic [4:0] OPC_LLI  = 5'b00010;
  localparam logic [4:0] OPC_LDR  = 5'b00011;
  localparam logic [4:0] OPC_STR  = 5'b00101;
  localparam logic [4:0] OPC_CMP  = 5'b00110;
  localparam logic [4:0] OPC_ADDI = 5'b00111;
  localparam logic [4:0] OPC_SUBI = 5'b01000;
  localparam logic [4:0] OPC_MOV  = 5'b01011;
  localparam logic [4:0] OPC_JMP  = 5'b10000;
  localparam logic [4:0] OPC_JAL  = 5'b10001;
  localparam logic [4:0] OPC_JALR = 5'b10010;
  localparam logic [4:0] OPC_JR   = 5'b10011;
  localparam logic [4:0] OPC_SYS  = 5'b11100;
  localparam logic [3:0] OPC_BR   = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam logic [1:0] A_S_ADD = 2'b00;
  localparam logic [1:0] A_S_ADC = 2'b01;
  localparam logic [1:0] A_S_SUB = 2'b10;
  localparam logic [1:0] A_S_SBC = 2'b11;

  localparam int OP_LSB   = 11;
  localparam int COND_LSB = 8;
  localparam int RD_LSB   = 8;
  localparam int RM_LSB   = 5;
  localparam int RN_LSB   = 2;

  function automatic logic is_legal(input logic [4:0] op);
    return op < OP_COUNT;
  endfunction

  function automatic logic [15:0] encode(input logic [4:0] op, input logic [2:0] rd,
                                         input logic [2:0] rm, input logic [2:0] rn,
                                         input logic [10:0] imm);
    logic [15:0] w;
    w = '0;
    case (op)
      OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
        w[OP_LSB +: 5] = OPC_ALU;
        w[RD_LSB +: 3] = rd;
        w[RM_LSB +: 3] = rm;
        w[RN_LSB +: 3] = rn;
        w[1:0] = (op == OP_ADD) ? A_S_ADD : (op == OP_ADC) ? A_S_ADC :
                 (op == OP_SUB) ? A_S_SUB : A_S_SBC;
      end
      OP_LHI, OP_LLI: begin
        w[OP_LSB +: 5] = (op == OP_LHI) ? OPC_LHI : OPC_LLI;
        w[RD_LSB +: 3] = rd;
        w[7:0] = imm[7:0];
      end
      OP_LDR, OP_STR, OP_ADDI, OP_SUBI: begin
        w[OP_LSB +: 5] = (op == OP_LDR) ? OPC_LDR : (op == OP_STR) ? OPC_STR :
                         (op == OP_ADDI) ? OPC_ADDI : OPC_SUBI;
        w[RD_LSB +: 3] = rd;
        w[RM_LSB +: 3] = rm;
        w[4:0] = imm[4:0];
      end
      OP_CMP: begin
        w[OP_LSB +: 5] = OPC_CMP;
        w[RM_LSB +: 3] = rm;
        w[RN_LSB +: 3] = rn;
      end
      OP_MOV, OP_JALR: begin
        w[OP_LSB +: 5] = (op == OP_MOV) ? OPC_MOV : OPC_JALR;
        w[RD_LSB +: 3] = rd;
        w[RM_LSB +: 3] = rm;
      end
      OP_BEQ, OP_BNE, OP_BCS, OP_BCC, OP_BAL: begin
        w[15:12] = OPC_BR;
        w[COND_LSB +: 4] = (op == OP_BEQ) ? COND_EQ : (op == OP_BNE) ? COND_NE :
                           (op == OP_BCS) ? COND_CS : (op == OP_BCC) ? COND_CC : COND_AL;
        w[7:0] = imm[7:0];
      end
      OP_JMP, OP_JAL: begin
        w[OP_LSB +: 5] = (op == OP_JMP) ? OPC_JMP : OPC_JAL;
        w[10:0] = imm;
      end
      OP_JR: begin
        w[OP_LSB +: 5] = OPC_JR;
        w[RD_LSB +: 3] = rd;
      end
      OP_OUTR: begin
        w[OP_LSB +: 5] = OPC_SYS;
        w[RD_LSB +: 3] = rd;
      end
      OP_HLT: begin
        w[OP_LSB +: 5] = OPC_SYS;
        w[0] = 1'b1;
      end
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Flop-based synchronous FIFO; write visible at the read port one cycle after push.
// Push is dropped when full and pop when empty; callers gate on the flags.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wr_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rd_dat_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      cnt_q;
  logic             do_push, do_pop;

  assign full_o   = (cnt_q == CNT_FULL);
  assign empty_o  = (cnt_q == '0);
  assign do_push  = push_i & ~full_o;
  assign do_pop   = pop_i & ~empty_o;
  assign rd_dat_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wr_dat_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: rtl/instr_encoder.sv
// Packs field bundles into 16-bit instructions and streams them with addresses to instruction memory.
// One-cycle accept-to-output latency; in_ready drops while the output FIFO is full.
module instr_encoder
  import isa_pkg::*;
#(
  parameter int AW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4:0]    in_op,
  input  logic [2:0]    in_rd,
  input  logic [2:0]    in_rm,
  input  logic [2:0]    in_rn,
  input  logic [10:0]   in_imm,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [15:0]   out_word,
  output logic [AW-1:0] out_addr,
  output logic          busy,
  output logic          done,
  output logic          err
);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_e;

  state_e        state_q, state_d;
  logic          busy_q, done_q, err_q, err_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          fifo_full, fifo_empty;
  logic          accept, push, pop;
  logic [15:0]   enc_word;

  assign in_ready  = (state_q == S_LOAD) & ~fifo_full;
  assign accept    = in_valid & in_ready;
  // Illegal ops complete the handshake but never reach memory.
  assign push      = accept & is_legal(in_op);
  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;
  assign enc_word  = encode(in_op, in_rd, in_rm, in_rn, in_imm);
  assign out_addr  = addr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

  sync_fifo #(.WIDTH(16), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_i   (push),
    .wr_dat_i (enc_word),
    .pop_i    (pop),
    .rd_dat_o (out_word),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    addr_d  = addr_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) begin
        state_d = S_LOAD;
        addr_d  = base_addr;
        err_d   = 1'b0;
      end
      S_LOAD:  if (accept && in_op == OP_HLT) state_d = S_DRAIN;
      S_DRAIN: if (fifo_empty) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
    if (accept && !is_legal(in_op)) err_d = 1'b1;
    if (pop) addr_d = addr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == S_LOAD) || (state_d == S_DRAIN);
      done_q  <= (state_d == S_DONE);
      err_q   <= err_d;
      addr_q  <= addr_d;
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder with hand-computed instruction words and addresses.
`timescale 1ns/1ps
module tb_instr_encoder;
  import isa_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_ready, out_valid, out_ready, busy, done, err;
  logic [7:0]  base_addr, out_addr;
  logic [4:0]  in_op;
  logic [2:0]  in_rd, in_rm, in_rn;
  logic [10:0] in_imm;
  logic [15:0] out_word;
  int          vectors = 0;
  int          miscompares = 0;

  instr_encoder #(.AW(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd),
    .in_rm(in_rm), .in_rn(in_rn), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .out_addr(out_addr), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input string tag, input logic [4:0] op, input logic [2:0] rd,
                      input logic [2:0] rm, input logic [2:0] rn, input logic [10:0] imm);
    int n;
    in_op = op; in_rd = rd; in_rm = rm; in_rn = rn; in_imm = imm;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) check({tag, " accept timeout"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic expect_word(input string tag, input logic [15:0] word, input logic [7:0] addr);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, " valid"}, 32'(out_valid), 32'd1);
    check({tag, " word"}, 32'(out_word), 32'(word));
    check({tag, " addr"}, 32'(out_addr), 32'(addr));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_rd = '0; in_rm = '0; in_rn = '0; in_imm = '0;
    tick(); tick();
    check("rst in_ready", 32'(in_ready), 0);
    check("rst out_valid", 32'(out_valid), 0);
    check("rst busy", 32'(busy), 0);
    check("rst done", 32'(done), 0);
    check("rst err", 32'(err), 0);
    check("rst out_word", 32'(out_word), 0);
    check("rst out_addr", 32'(out_addr), 0);
    rst = 1'b0;
    tick();

    // Basic encode
    start = 1'b1; base_addr = 8'h10;
    tick();
    start = 1'b0;
    check("load busy", 32'(busy), 1);
    check("load in_ready", 32'(in_ready), 1);
    send("add", OP_ADD, 3'd1, 3'd2, 3'd3, 11'd0);
    check("add latency", 32'(out_valid), 1);
    expect_word("add", 16'h014C, 8'h10);
    send("lli", OP_LLI, 3'd2, 3'd0, 3'd0, 11'h05A);
    expect_word("lli", 16'h125A, 8'h11);

    // Fill the FIFO under backpressure, fifth bundle must stall
    send("bne", OP_BNE, 3'd0, 3'd0, 3'd0, 11'h7FD);
    send("bal", OP_BAL, 3'd0, 3'd0, 3'd0, 11'h004);
    send("jmp", OP_JMP, 3'd0, 3'd0, 3'd0, 11'h123);
    send("outr", OP_OUTR, 3'd5, 3'd0, 3'd0, 11'd0);
    check("full in_ready", 32'(in_ready), 0);
    in_op = OP_ADDI; in_rd = 3'd3; in_rm = 3'd4; in_imm = 11'h1F5; in_valid = 1'b1;
    start = 1'b1; base_addr = 8'h80;
    tick(); tick(); tick();
    start = 1'b0;
    check("stall in_ready", 32'(in_ready), 0);
    check("stall word held", 32'(out_word), 32'h0000C1FD);
    check("stall addr held", 32'(out_addr), 32'h12);
    in_valid = 1'b0;
    expect_word("bne", 16'hC1FD, 8'h12);
    expect_word("bal", 16'hCE04, 8'h13);
    expect_word("jmp", 16'h8123, 8'h14);
    expect_word("outr", 16'hE500, 8'h15);
    check("drained out_valid", 32'(out_valid), 0);
    send("addi", OP_ADDI, 3'd3, 3'd4, 3'd0, 11'h1F5);
    expect_word("addi", 16'h3B95, 8'h16);
    send("cmp", OP_CMP, 3'd0, 3'd6, 3'd7, 11'd0);
    expect_word("cmp", 16'h30DC, 8'h17);
    send("str", OP_STR, 3'd1, 3'd2, 3'd0, 11'd3);
    expect_word("str", 16'h2943, 8'h18);

    // HLT ends the session
    send("mov", OP_MOV, 3'd7, 3'd1, 3'd0, 11'd0);
    send("hlt", OP_HLT, 3'd0, 3'd0, 3'd0, 11'd0);
    check("drain busy", 32'(busy), 1);
    check("drain in_ready", 32'(in_ready), 0);
    check("drain done", 32'(done), 0);
    expect_word("mov", 16'h5F20, 8'h19);
    expect_word("hlt", 16'hE001, 8'h1A);
    tick();
    check("done flag", 32'(done), 1);
    check("done busy", 32'(busy), 0);
    check("done in_ready", 32'(in_ready), 0);
    tick(); tick(); tick();
    check("done hold", 32'(done), 1);
    check("done hold in_ready", 32'(in_ready), 0);

    // Illegal op and address wrap
    start = 1'b1; base_addr = 8'hFF;
    tick();
    start = 1'b0;
    check("wrap busy", 32'(busy), 1);
    check("wrap err clear", 32'(err), 0);
    send("illegal", 5'd25, 3'd1, 3'd1, 3'd1, 11'h7FF);
    check("illegal no word", 32'(out_valid), 0);
    check("illegal err", 32'(err), 1);
    send("lhi", OP_LHI, 3'd4, 3'd0, 3'd0, 11'h3AB);
    expect_word("lhi", 16'h0CAB, 8'hFF);
    send("jr", OP_JR, 3'd2, 3'd0, 3'd0, 11'd0);
    expect_word("jr", 16'h9A00, 8'h00);
    check("err sticky", 32'(err), 1);
    send("hlt2", OP_HLT, 3'd0, 3'd0, 3'd0, 11'd0);
    expect_word("hlt2", 16'hE001, 8'h01);
    tick();
    check("done2", 32'(done), 1);
    check("done2 err", 32'(err), 1);
    start = 1'b1; base_addr = 8'h40;
    tick();
    start = 1'b0;
    check("restart err", 32'(err), 0);
    check("restart done", 32'(done), 0);
    check("restart busy", 32'(busy), 1);

    // Reset mid-load discards queued words
    send("sub", OP_SUB, 3'd1, 3'd1, 3'd1, 11'd0);
    send("sbc", OP_SBC, 3'd2, 3'd3, 3'd4, 11'd0);
    send("jal", OP_JAL, 3'd0, 3'd0, 3'd0, 11'h7FF);
    check("queued valid", 32'(out_valid), 1);
    check("queued word", 32'(out_word), 32'h0126);
    check("queued addr", 32'(out_addr), 32'h40);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid rst out_valid", 32'(out_valid), 0);
    check("mid rst busy", 32'(busy), 0);
    check("mid rst addr", 32'(out_addr), 0);
    check("mid rst in_ready", 32'(in_ready), 0);
    check("mid rst word", 32'(out_word), 0);
    out_ready = 1'b1;
    tick(); tick();
    check("post rst out_valid", 32'(out_valid), 0);
    check("post rst addr", 32'(out_addr), 0);
    out_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
